sti_tx_scheduler: RTL

- Sits in front of the serial-transmit/DAC datapath.
- Arbitrates up to NREQ word producers using round-robin and issues one word at a time as a load pulse plus pi_* fields.
- Holds the pi_* fields stable for the whole serialization and waits for the serial burst to finish before issuing the next word.
- After every enabled requester has sent its last word, raises pi_end and waits for oem_finish.

---
 rtl/sti_sched_pkg.sv | 31 +++
 rtl/sti_tx_scheduler_rr_arbiter.sv | 24 ++
 rtl/sti_tx_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sti_sched_pkg.sv
// Shared types and helpers for the serial-transmit word scheduler.
package sti_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    WAIT_START,
    WAIT_DONE,
    CHECK,
    END,
    DONE
  } state_t;

  // Length codes as presented on req_length / pi_length.
  localparam logic [1:0] LEN_8  = 2'd0;
  localparam logic [1:0] LEN_16 = 2'd1;
  localparam logic [1:0] LEN_24 = 2'd2;
  localparam logic [1:0] LEN_32 = 2'd3;

  // Bit positions inside a per-requester cfg nibble {fill, msb, low, last}.
  localparam int FILL = 3;
  localparam int MSB  = 2;
  localparam int LOW  = 1;
  localparam int LAST = 0;

  function automatic logic [5:0] bits_for_len(input logic [1:0] len);
    return 6'({len, 3'b000}) + 6'd8;
  endfunction

endpackage

// File: rtl/sti_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
module sti_tx_scheduler_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!valid && req[i] && (i == (int'(ptr) + off) % NREQ)) begin
          grant[i] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sti_tx_scheduler.sv
// Round-robin word scheduler in front of the serial-transmit/DAC datapath.
// Optional per-word bit-count check is built when STI_SCHED_BITCHECK_EN is defined.
module sti_tx_scheduler
  import sti_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int WDOG = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [16*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0] req_length,
  input  logic [4*NREQ-1:0] req_cfg,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  input  logic              so_valid,
  input  logic              oem_finish,
  output logic [1:0]        grant_id,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef STI_SCHED_BITCHECK_EN
  ,
  output logic [5:0]        bit_count_last
`endif
);

  localparam int WD_W = $clog2(WDOG + 1);

  state_t            state, next_state;
  logic [NREQ-1:0]   active, retired;
  logic [1:0]        rr;
  logic [WD_W-1:0]   wd_cnt;

  logic [NREQ-1:0]   arb_grant;
  logic              arb_valid;
  logic              take_grant;
  logic              wd_expire;
  logic              proto_err;
  logic              bit_err;
  logic              err_set;

  logic [15:0]       sel_data;
  logic [1:0]        sel_len;
  logic [3:0]        sel_cfg;
  logic [1:0]        sel_idx;

  sti_tx_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (active & ~retired & req_valid),
    .ptr   (rr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    sel_cfg  = '0;
    sel_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_data = req_data[16*i +: 16];
        sel_len  = req_length[2*i +: 2];
        sel_cfg  = req_cfg[4*i +: 4];
        sel_idx  = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    take_grant = 1'b0;
    wd_expire  = 1'b0;
    case (state)
      IDLE:       next_state = (req_en == '0) ? END : ARB;
      ARB: begin
        if (arb_valid) begin
          take_grant = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD:       next_state = WAIT_START;
      WAIT_START: begin
        if (so_valid) begin
          next_state = WAIT_DONE;
        end else if (wd_cnt == WD_W'(WDOG - 1)) begin
          wd_expire  = 1'b1;
          next_state = ARB;
        end
      end
      WAIT_DONE:  if (!so_valid) next_state = CHECK;
      CHECK:      next_state = ((active & ~retired) == '0) ? END : ARB;
      END:        if (oem_finish) next_state = DONE;
      DONE:       next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // The serializer must stay quiet whenever no word is in flight.
  assign proto_err = so_valid && (state == ARB || state == LOAD || state == CHECK);
  assign err_set   = wd_expire | proto_err | bit_err;

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active    <= '0;
      retired   <= '0;
      rr        <= '0;
      wd_cnt    <= '0;
      load      <= 1'b0;
      pi_data   <= '0;
      pi_length <= '0;
      pi_fill   <= 1'b0;
      pi_msb    <= 1'b0;
      pi_low    <= 1'b0;
      pi_end    <= 1'b0;
      req_ready <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      load      <= (next_state == LOAD);
      busy      <= (next_state != IDLE) && (next_state != DONE);
      pi_end    <= (next_state == END) || (next_state == DONE);
      done      <= done | (next_state == DONE);
      err       <= err | err_set;
      req_ready <= take_grant ? arb_grant : '0;
      if (state == IDLE) active <= req_en;
      if (state == LOAD)            wd_cnt <= '0;
      else if (state == WAIT_START) wd_cnt <= wd_cnt + WD_W'(1);
      if (take_grant) begin
        pi_data   <= sel_data;
        pi_length <= sel_len;
        pi_fill   <= sel_cfg[FILL];
        pi_msb    <= sel_cfg[MSB];
        pi_low    <= sel_cfg[LOW];
        grant_id  <= sel_idx;
        rr        <= sel_idx;
        if (sel_cfg[LAST]) retired <= retired | arb_grant;
      end
    end
  end

`ifdef STI_SCHED_BITCHECK_EN
  logic [5:0] bit_cnt;

  // The first so_valid cycle is consumed in WAIT_START, so counting starts at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt        <= '0;
      bit_count_last <= '0;
    end else begin
      if (state == WAIT_START && so_valid)
        bit_cnt <= 6'd1;
      else if (state == WAIT_DONE && so_valid && bit_cnt != 6'h3f)
        bit_cnt <= bit_cnt + 6'd1;
      if (state == WAIT_DONE && !so_valid)
        bit_count_last <= bit_cnt;
    end
  end

  assign bit_err = (state == CHECK) && (bit_cnt != bits_for_len(pi_length));
`else
  assign bit_err = 1'b0;
`endif

endmodule
